// File: rtl/accumulator_alu.sv
// accumulator_alu
//   WIDTH-bit accumulator register with an operation unit. It supports load,
//   add, subtract, AND, XOR and multi-cycle logical shifts. It produces Z/N/C/V
//   status flags and a busy/done handshake toward the control unit.
//
//   Opcodes (ac_op): 000 NOP, 001 LOAD, 010 ADD, 011 SUB,
//                    100 AND, 101 XOR, 110 SHL, 111 SHR
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   ac_en    in   command strobe, taken only while busy=0
//   ac_op    in   opcode
//   data_in  in   operand; shift amount is data_in[SHW-1:0]
//   data_out out  accumulator contents
//   busy     out  high while a multi-cycle shift runs
//   done     out  one-cycle pulse after an accepted command completes
//   zero     out  data_out == 0
//   neg      out  data_out MSB
//   carry    out  carry / borrow / last bit shifted out
//   ovf      out  signed overflow of ADD/SUB
//
// Build option
//   ACC_SATURATE_EN: when defined, an ADD/SUB that overflows clamps to the
//   signed limit instead of wrapping. ovf and carry still report the
//   unsaturated computation.
//
// States
//   IDLE  | accepts commands, executes single-cycle ops
//   SHIFT | shifts one bit per edge until the counter reaches 0, ignores ac_en

module accumulator_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ac_en,
  input  logic [2:0]       ac_op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

`ifdef ACC_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic             shr_dir, shr_dir_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry_nxt, ovf_nxt, done_nxt;

  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic             add_ovf, sub_ovf;

  assign shamt = data_in[SHW-1:0];
  assign sum   = {1'b0, data_out} + {1'b0, data_in};
  assign diff  = {1'b0, data_out} - {1'b0, data_in};

  // diff[WIDTH] is the borrow: it is set exactly when data_out < data_in (unsigned)
  assign add_ovf = (data_out[WIDTH-1] == data_in[WIDTH-1]) &&
                   (sum[WIDTH-1] != data_out[WIDTH-1]);
  assign sub_ovf = (data_out[WIDTH-1] != data_in[WIDTH-1]) &&
                   (diff[WIDTH-1] != data_out[WIDTH-1]);

  assign busy = (state == SHIFT);
  assign zero = (data_out == '0);
  assign neg  = data_out[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shr_dir  <= 1'b0;
      data_out <= '0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shr_dir  <= shr_dir_nxt;
      data_out <= acc_nxt;
      carry    <= carry_nxt;
      ovf      <= ovf_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shr_dir_nxt = shr_dir;
    acc_nxt     = data_out;
    carry_nxt   = carry;
    ovf_nxt     = ovf;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (ac_en) begin
          done_nxt = 1'b1;
          case (ac_op)
            OP_LOAD: begin
              acc_nxt   = data_in;
              carry_nxt = 1'b0;
              ovf_nxt   = 1'b0;
            end
            OP_ADD: begin
              acc_nxt   = sum[WIDTH-1:0];
              carry_nxt = sum[WIDTH];
              ovf_nxt   = add_ovf;
`ifdef ACC_SATURATE_EN
              // on overflow the true result has the sign of the accumulator
              if (add_ovf) acc_nxt = data_out[WIDTH-1] ? SAT_NEG : SAT_POS;
`endif
            end
            OP_SUB: begin
              acc_nxt   = diff[WIDTH-1:0];
              carry_nxt = diff[WIDTH];
              ovf_nxt   = sub_ovf;
`ifdef ACC_SATURATE_EN
              if (sub_ovf) acc_nxt = data_out[WIDTH-1] ? SAT_NEG : SAT_POS;
`endif
            end
            OP_AND: begin
              acc_nxt   = data_out & data_in;
              carry_nxt = 1'b0;
              ovf_nxt   = 1'b0;
            end
            OP_XOR: begin
              acc_nxt   = data_out ^ data_in;
              carry_nxt = 1'b0;
              ovf_nxt   = 1'b0;
            end
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                carry_nxt = 1'b0;
                ovf_nxt   = 1'b0;
              end else begin
                // done comes from the last shift step instead
                done_nxt    = 1'b0;
                state_nxt   = SHIFT;
                cnt_nxt     = shamt;
                shr_dir_nxt = ac_op[0];
              end
            end
            default: ;
          endcase
        end
      end
      SHIFT: begin
        ovf_nxt = 1'b0;
        if (shr_dir) begin
          acc_nxt   = data_out >> 1;
          carry_nxt = data_out[0];
        end else begin
          acc_nxt   = data_out << 1;
          carry_nxt = data_out[WIDTH-1];
        end
        cnt_nxt = cnt - 1'b1;
        if (cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_accumulator_alu.sv
// tb_accumulator_alu
//   Randomized and directed stimulus for accumulator_alu (WIDTH=8). Each
//   response is compared against an arithmetic reference model of the
//   accumulator and its flags.

module tb_accumulator_alu;

  localparam int W    = 8;
  localparam int MOD  = 2 ** W;
  localparam int HALF = 2 ** (W - 1);
  localparam int KMOD = 2 ** $clog2(W);

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] ANDOP = 3'd4, XOROP = 3'd5, SHL = 3'd6, SHR = 3'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ac_en = 1'b0;
  logic [2:0]   ac_op = 3'd0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         busy, done, zero, neg, carry, ovf;

  int checks = 0;
  int failures = 0;

  int m_acc = 0;
  bit m_c = 1'b0;
  bit m_v = 1'b0;

  accumulator_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ac_en(ac_en), .ac_op(ac_op), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done), .zero(zero), .neg(neg),
    .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit exp_busy, input bit exp_done);
    chk({tag, ".acc"},   32'(data_out), 32'(m_acc));
    chk({tag, ".zero"},  32'(zero),     32'(m_acc == 0));
    chk({tag, ".neg"},   32'(neg),      32'(m_acc >= HALF));
    chk({tag, ".carry"}, 32'(carry),    32'(m_c));
    chk({tag, ".ovf"},   32'(ovf),      32'(m_v));
    chk({tag, ".busy"},  32'(busy),     32'(exp_busy));
    chk({tag, ".done"},  32'(done),     32'(exp_done));
  endtask

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // single-cycle operations, computed with plain integer arithmetic
  task automatic model_op(input logic [2:0] op, input int d);
    int s;
    int sres;
    case (op)
      LOAD:  begin m_acc = d; m_c = 0; m_v = 0; end
      ADD: begin
        s     = m_acc + d;
        sres  = sgn(m_acc) + sgn(d);
        m_c   = (s >= MOD);
        m_v   = (sres > HALF - 1) || (sres < -HALF);
        m_acc = s % MOD;
`ifdef ACC_SATURATE_EN
        if (m_v) m_acc = (sres > 0) ? HALF - 1 : HALF;
`endif
      end
      SUB: begin
        sres  = sgn(m_acc) - sgn(d);
        m_c   = (m_acc < d);
        m_v   = (sres > HALF - 1) || (sres < -HALF);
        m_acc = (m_acc - d + MOD) % MOD;
`ifdef ACC_SATURATE_EN
        if (m_v) m_acc = (sres > 0) ? HALF - 1 : HALF;
`endif
      end
      ANDOP: begin m_acc = m_acc & d; m_c = 0; m_v = 0; end
      XOROP: begin m_acc = m_acc ^ d; m_c = 0; m_v = 0; end
      SHL, SHR: begin m_c = 0; m_v = 0; end
      default: ;
    endcase
  endtask

  // Issue one command and follow it to completion. With spam set, a LOAD 0 is
  // held on the bus for the whole shift and must be ignored.
  task automatic do_cmd(input string tag, input logic [2:0] op, input int d, input bit spam);
    int k;
    k = d % KMOD;
    @(negedge clk);
    ac_en = 1'b1; ac_op = op; data_in = W'(d);
    @(negedge clk);
    if ((op == SHL || op == SHR) && k > 0) begin
      ac_en = spam; ac_op = LOAD; data_in = '0;
      chk_all({tag, ".e0"}, 1'b1, 1'b0);
      for (int i = 1; i <= k; i++) begin
        @(negedge clk);
        if (op == SHL) begin
          m_c   = (m_acc >= HALF);
          m_acc = (m_acc * 2) % MOD;
        end else begin
          m_c   = m_acc % 2;
          m_acc = m_acc / 2;
        end
        m_v = 0;
        if (i == k) ac_en = 1'b0;
        chk_all($sformatf("%s.step%0d", tag, i), i != k, i == k);
      end
    end else begin
      ac_en = 1'b0;
      model_op(op, d);
      chk_all({tag, ".acc_edge"}, 1'b0, 1'b1);
    end
    @(negedge clk);
    chk_all({tag, ".after"}, 1'b0, 1'b0);
  endtask

  initial begin
    // reset asserted from time 0, checked before the first clock edge
    #2;
    chk_all("reset0", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    do_cmd("t2.load", LOAD, 'h0F, 1'b0);
    do_cmd("t2.add",  ADD,  'hF5, 1'b0);
    chk("t2.val", 32'(data_out), 32'h04);

    do_cmd("t3.load", LOAD, 'h7F, 1'b0);
    do_cmd("t3.add",  ADD,  'h01, 1'b0);

    do_cmd("t4.load", LOAD, 'h05, 1'b0);
    do_cmd("t4.sub",  SUB,  'h06, 1'b0);
    chk("t4.val", 32'(data_out), 32'hFF);

    do_cmd("t5.load", LOAD, 'hB1, 1'b0);
    do_cmd("t5.shl",  SHL,  3,    1'b1);
    chk("t5.val", 32'(data_out), 32'h88);

    do_cmd("k0.shr", SHR, 'h08, 1'b0);
    do_cmd("nop",    NOP, 'hA5, 1'b0);

    // reset in the middle of a shift
    do_cmd("t6.load", LOAD, 'hFF, 1'b0);
    @(negedge clk);
    ac_en = 1'b1; ac_op = SHR; data_in = W'(7);
    @(negedge clk);
    ac_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6.mid_acc",  32'(data_out), 32'h3F);
    chk("t6.mid_busy", 32'(busy),     32'd1);
    #1 rst = 1'b0;
    #1;
    m_acc = 0; m_c = 0; m_v = 0;
    chk_all("t6.async", 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_all("t6.post1", 1'b0, 1'b0);
    @(negedge clk);
    chk_all("t6.post2", 1'b0, 1'b0);
    do_cmd("t6.reload", LOAD, 'h5A, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0] op;
      int d;
      bit spam;
      op   = 3'($urandom_range(0, 7));
      d    = int'($urandom_range(0, MOD - 1));
      spam = 1'($urandom_range(0, 1));
      do_cmd($sformatf("rnd%0d", n), op, d, spam);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
